// File: rtl/uart_rx_oversampled.sv
// UART receiver. It synchronises the serial line, detects the start bit and samples
// each bit at mid-bit on the oversampled baud tick. Frames are assembled LSB first.
module uart_rx_oversampled #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Tick,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxFrameErr,
  output logic                 RxBusy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] START_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_MID   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [1:0]           r_sync_fill;
  logic [CW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 w_busy;
  logic                 w_mid;
  logic                 w_shift_en;
  logic                 w_good;
  logic                 w_bad;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_busy      = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    w_mid       = Tick && w_busy &&
                  (r_tick_cnt == ((r_state == S_START) ? START_MID : BIT_MID));
    unique case (r_state)
      // The reset value of the synchroniser is not a line sample, so the idle check
      // waits until real samples have reached rx_s. A line held low across reset is
      // therefore never taken for a start bit.
      S_WAIT_IDLE: if (r_sync_fill[1] && r_rx_s) w_state_nxt = S_IDLE;
      S_IDLE:      if (!r_rx_s) w_state_nxt = S_START;
      S_START:     if (w_mid) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_mid) begin
          if (r_rx_s) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_sync_fill <= '0;
      r_state     <= S_WAIT_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
    end else begin
      r_rx_meta   <= Rx;
      r_rx_s      <= r_rx_meta;
      r_sync_fill <= {r_sync_fill[0], 1'b1};
      r_state     <= w_state_nxt;
      // The counter restarts on every state entry and after each mid-bit sample.
      if ((w_state_nxt != r_state) || w_mid) begin
        r_tick_cnt <= '0;
      end else if (Tick && w_busy) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
      if (w_good || w_bad) r_data <= r_shift;
      r_valid <= w_good;
      r_ferr  <= w_bad;
    end
  end

  assign RxData     = r_data;
  assign RxValid    = r_valid;
  assign RxFrameErr = r_ferr;
  assign RxBusy     = w_busy;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled. Each frame sent pushes its expected outcome,
// and every output pulse pops and checks the oldest entry.
module tb_uart_rx_oversampled;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tick;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxFrameErr;
  logic       RxBusy;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 Clk = ~Clk;

  uart_rx_oversampled #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Tick      (Tick),
    .Rx        (Rx),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxFrameErr(RxFrameErr),
    .RxBusy    (RxBusy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle. Tick fires every 4th cycle, so one bit lasts 64 Clk.
  task automatic step();
    exp_t e;
    Tick = (cyc % 4 == 3);
    @(posedge Clk);
    #1;
    cyc++;
    if (RxValid === 1'b1 || RxFrameErr === 1'b1) begin
      chk("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
      chk("valid_err_exclusive", {31'b0, RxValid & RxFrameErr}, 32'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rx_valid", {31'b0, RxValid}, {31'b0, !e.err});
        chk("rx_frame_err", {31'b0, RxFrameErr}, {31'b0, e.err});
        chk("rx_data", {24'b0, RxData}, {24'b0, e.data});
      end
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (64) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_q.push_back({!stop, d});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    logic [7:0] d;
    Rst  = 1'b1;
    Rx   = 1'b1;
    Tick = 1'b0;
    repeat (4) step();
    chk("reset_data", {24'b0, RxData}, 32'h0);
    chk("reset_valid", {31'b0, RxValid}, 32'd0);
    chk("reset_ferr", {31'b0, RxFrameErr}, 32'd0);
    chk("reset_busy", {31'b0, RxBusy}, 32'd0);
    Rst = 1'b0;
    repeat (20) step();

    // Good frame 0xA5, checking the busy latency from the start edge.
    d = 8'hA5;
    exp_q.push_back({1'b0, d});
    Rx = 1'b0;
    step();
    step();
    chk("busy_before_3clk", {31'b0, RxBusy}, 32'd0);
    step();
    chk("busy_at_3clk", {31'b0, RxBusy}, 32'd1);
    repeat (61) step();
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    chk("a5_received", exp_q.size(), 32'd0);
    chk("a5_busy_low", {31'b0, RxBusy}, 32'd0);
    chk("a5_data_hold", {24'b0, RxData}, 32'hA5);
    repeat (30) step();

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    chk("b2b_received", exp_q.size(), 32'd0);
    repeat (40) step();

    // False start: a short low glitch on an idle line.
    Rx = 1'b0;
    repeat (10) step();
    chk("glitch_busy", {31'b0, RxBusy}, 32'd1);
    repeat (10) step();
    Rx = 1'b1;
    repeat (80) step();
    chk("glitch_idle", {31'b0, RxBusy}, 32'd0);
    send_frame(8'h3C, 1'b1);
    chk("3c_received", exp_q.size(), 32'd0);
    repeat (40) step();

    // Framing error, then the line stays low for five more bit times.
    send_frame(8'h81, 1'b0);
    repeat (5) send_bit(1'b0);
    chk("ferr_reported", exp_q.size(), 32'd0);
    chk("ferr_no_busy_low_line", {31'b0, RxBusy}, 32'd0);
    chk("ferr_data", {24'b0, RxData}, 32'h81);
    Rx = 1'b1;
    repeat (64) step();
    send_frame(8'h42, 1'b1);
    chk("42_received", exp_q.size(), 32'd0);
    repeat (40) step();

    // Reset during data bit 4 of 0x96; the aborted frame must produce no pulse.
    d = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    Rx = d[4];
    repeat (30) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("rst_mid_data", {24'b0, RxData}, 32'h0);
    chk("rst_mid_busy", {31'b0, RxBusy}, 32'd0);
    Rx = 1'b1;
    repeat (128) step();
    chk("rst_mid_idle", {31'b0, RxBusy}, 32'd0);
    send_frame(8'h96, 1'b1);
    chk("96_received", exp_q.size(), 32'd0);
    repeat (40) step();

    // Line held low across reset release.
    Rx  = 1'b0;
    Rst = 1'b1;
    repeat (3) step();
    Rst = 1'b0;
    repeat (200) step();
    chk("low_line_busy", {31'b0, RxBusy}, 32'd0);
    Rx = 1'b1;
    repeat (64) step();
    send_frame(8'h5A, 1'b1);
    repeat (40) step();
    chk("5a_received", exp_q.size(), 32'd0);
    chk("5a_data", {24'b0, RxData}, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
